uart_host_endpoint: RTL and testbench

// - Host-side counterpart of the FPGA UART processor link. Used for board-to-board links and loopback benches.
// - Packs INP_WIDTH packets from an AXI-Stream slave into UART bytes on txd.
// - Reassembles bytes arriving on rxd into OUT_WIDTH words on an AXI-Stream master.
// - Byte order and padding match the processor side: LSB byte first, zero-padded top byte, 8N1 framing.

---
 rtl/uart_host_endpoint_pkg.sv | 42 ++++
 rtl/uart_host_endpoint_uart.sv | 184 ++++++++++++++++++
 rtl/uart_host_endpoint_unpacker.sv | 115 +++++++++++
 rtl/uart_host_endpoint.sv | 143 ++++++++++++++
 tb/tb_uart_host_endpoint.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_host_endpoint_pkg.sv
// -----------------------------------------------------------------------------
// Shared configuration packages for the host-side UART link.
//   uart_config      : UART character geometry, baud helpers, TX FSM state type.
//                      The processor-side UART wrapper imports the same package,
//                      so both ends of the link derive identical bit timing.
//   processor_config : packet widths of the processor link.
//                      INP_WIDTH: host -> processor, OUT_WIDTH: processor -> host.
// No ports (packages only).
// -----------------------------------------------------------------------------
package uart_config;

  localparam int UART_WIDTH = 8;  // data bits per character
  localparam int UART_PADS  = 2;  // start + stop bit around each character

  // Clocks per 1/8 bit; the uart core runs an 8x prescaled bit timer.
  function automatic int calc_prescale(real clk, int baud);
    return $rtoi(clk / (8.0 * real'(baud)));
  endfunction

  // Clocks per 10-bit character, rounded up.
  function automatic int calc_char_clocks(real clk, int baud);
    real r;
    int  n;
    r = clk * 10.0 / real'(baud);
    n = $rtoi(r);
    if (real'(n) < r) n = n + 1;
    return n;
  endfunction

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

package processor_config;

  localparam int INP_WIDTH = 12;
  localparam int OUT_WIDTH = 20;

endpackage

// File: rtl/uart_host_endpoint_uart.sv
// -----------------------------------------------------------------------------
// uart_core: 8N1 UART transmitter and receiver with byte-wide AXI-Stream sides.
// Bit period is 8*prescale clocks. The receiver samples the middle of each bit
// after a synchronised falling edge on rxd.
// Ports:
//   clk, arstn            clock, asynchronous active-low reset
//   prescale              clocks per 1/8 bit (constant from the top level)
//   tx_tdata/tvalid/tready byte to transmit
//   rx_tdata/tvalid/tready received byte, held until taken
//   rxd / txd             serial line in / out (idle high)
//   tx_busy / rx_busy     frame in progress
//   frame_err             one-cycle pulse: stop bit sampled low
//   overrun_err           one-cycle pulse: byte completed while previous still held
// -----------------------------------------------------------------------------
module uart_core
  import uart_config::*;
(
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [15:0]           prescale,
  input  logic [UART_WIDTH-1:0] tx_tdata,
  input  logic                  tx_tvalid,
  output logic                  tx_tready,
  output logic [UART_WIDTH-1:0] rx_tdata,
  output logic                  rx_tvalid,
  input  logic                  rx_tready,
  input  logic                  rxd,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  rx_busy,
  output logic                  frame_err,
  output logic                  overrun_err
);

  logic [18:0] full_period;
  logic [18:0] half_period;

  assign full_period = {prescale, 3'b000} - 19'd1;
  assign half_period = {1'b0, prescale, 2'b00} - 19'd1;

  // ---------------------------------------------------------------- transmit
  logic [18:0] tx_cnt_q,   tx_cnt_d;
  logic [8:0]  tx_shreg_q, tx_shreg_d;  // data bits followed by the stop bit
  logic [3:0]  tx_bits_q,  tx_bits_d;
  logic        tx_busy_q,  tx_busy_d;
  logic        txd_q,      txd_d;

  assign tx_tready = !tx_busy_q;
  assign tx_busy   = tx_busy_q;
  assign txd       = txd_q;

  always_comb begin
    tx_cnt_d   = tx_cnt_q;
    tx_shreg_d = tx_shreg_q;
    tx_bits_d  = tx_bits_q;
    tx_busy_d  = tx_busy_q;
    txd_d      = txd_q;
    if (!tx_busy_q) begin
      if (tx_tvalid) begin
        tx_busy_d  = 1'b1;
        txd_d      = 1'b0;                 // start bit
        tx_shreg_d = {1'b1, tx_tdata};
        tx_bits_d  = 4'd9;
        tx_cnt_d   = full_period;
      end
    end else if (tx_cnt_q != 19'd0) begin
      tx_cnt_d = tx_cnt_q - 19'd1;
    end else if (tx_bits_q != 4'd0) begin
      txd_d      = tx_shreg_q[0];
      tx_shreg_d = {1'b0, tx_shreg_q[8:1]};
      tx_bits_d  = tx_bits_q - 4'd1;
      tx_cnt_d   = full_period;
    end else begin
      // Full stop-bit period has elapsed.
      tx_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tx_cnt_q   <= '0;
      tx_shreg_q <= '0;
      tx_bits_q  <= '0;
      tx_busy_q  <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_cnt_q   <= tx_cnt_d;
      tx_shreg_q <= tx_shreg_d;
      tx_bits_q  <= tx_bits_d;
      tx_busy_q  <= tx_busy_d;
      txd_q      <= txd_d;
    end
  end

  // ----------------------------------------------------------------- receive
  logic                  rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [18:0]           rx_cnt_q,    rx_cnt_d;
  logic [3:0]            rx_bit_q,    rx_bit_d;   // 0 start, 1..8 data, 9 stop
  logic                  rx_active_q, rx_active_d;
  logic [UART_WIDTH-1:0] rx_shreg_q,  rx_shreg_d;
  logic [UART_WIDTH-1:0] rx_data_q,   rx_data_d;
  logic                  rx_valid_q,  rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q,   overrun_d;

  assign rx_tdata    = rx_data_q;
  assign rx_tvalid   = rx_valid_q;
  assign rx_busy     = rx_active_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;

  always_comb begin
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_active_d = rx_active_q;
    rx_shreg_d  = rx_shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (rx_valid_q && rx_tready) rx_valid_d = 1'b0;

    if (!rx_active_q) begin
      if (rxd_prev_q && !rxd_sync_q) begin
        rx_active_d = 1'b1;
        rx_bit_d    = 4'd0;
        rx_cnt_d    = half_period;         // land in the middle of the start bit
      end
    end else if (rx_cnt_q != 19'd0) begin
      rx_cnt_d = rx_cnt_q - 19'd1;
    end else begin
      rx_cnt_d = full_period;
      if (rx_bit_q == 4'd0) begin
        // A start bit that is high again at mid-bit was a glitch.
        if (rxd_sync_q) rx_active_d = 1'b0;
        else            rx_bit_d    = 4'd1;
      end else if (rx_bit_q <= 4'd8) begin
        rx_shreg_d = {rxd_sync_q, rx_shreg_q[UART_WIDTH-1:1]};
        rx_bit_d   = rx_bit_q + 4'd1;
      end else begin
        rx_active_d = 1'b0;
        if (!rxd_sync_q) begin
          frame_err_d = 1'b1;
        end else if (rx_valid_q && !rx_tready) begin
          // Keep the byte already held; the new one is lost.
          overrun_d = 1'b1;
        end else begin
          rx_data_d  = rx_shreg_q;
          rx_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rxd_prev_q  <= 1'b1;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_active_q <= 1'b0;
      rx_shreg_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd;
      rxd_sync_q  <= rxd_meta_q;
      rxd_prev_q  <= rxd_sync_q;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_active_q <= rx_active_d;
      rx_shreg_q  <= rx_shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: rtl/uart_host_endpoint_unpacker.sv
// -----------------------------------------------------------------------------
// uart_word_unpacker: reassembles received UART bytes (LSB byte first) into
// OUT_WIDTH-bit words held in a single output register.
// Optional macro HOST_RX_TIMEOUT_EN adds a silence timer that drops a partial
// word after TIMEOUT_CYCLES clocks without a byte and sets sticky rx_timeout.
// Ports:
//   clk, arstn                   clock, asynchronous active-low reset
//   rx_tdata/tvalid/tready       bytes from the uart core
//   m_axis_tdata/tvalid/tready   assembled words
//   rx_timeout                   sticky partial-word timeout (0 without macro)
// -----------------------------------------------------------------------------
module uart_word_unpacker
  import uart_config::*;
#(
  parameter int OUT_WIDTH      = 20,
  parameter int TIMEOUT_CYCLES = 12800
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [UART_WIDTH-1:0] rx_tdata,
  input  logic                  rx_tvalid,
  output logic                  rx_tready,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  rx_timeout
);

  localparam int OUT_BYTES = (OUT_WIDTH + 7) / 8;
  localparam int IDX_W     = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  logic [8*OUT_BYTES-1:0] asm_q,    asm_d;
  logic [IDX_W-1:0]       idx_q,    idx_d;
  logic [OUT_WIDTH-1:0]   m_data_q, m_data_d;
  logic                   m_valid_q, m_valid_d;
  logic                   accept;

  // One holding register: no byte is taken while a word waits downstream.
  assign rx_tready     = !m_valid_q;
  assign accept        = rx_tvalid && !m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;

`ifdef HOST_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  logic             timeout_q, timeout_d;
  assign rx_timeout = timeout_q;
`else
  assign rx_timeout = 1'b0;
`endif

  always_comb begin
    asm_d     = asm_q;
    idx_d     = idx_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;

    if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;

    if (accept) begin
      asm_d[{idx_q, 3'b000} +: 8] = rx_tdata;
      if (idx_q == IDX_W'(OUT_BYTES - 1)) begin
        m_data_d  = asm_d[OUT_WIDTH-1:0];  // pad bits of the top byte dropped
        m_valid_d = 1'b1;
        idx_d     = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

`ifdef HOST_RX_TIMEOUT_EN
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
    // An arriving byte takes priority over an expiring count.
    if (idx_q == '0 || accept) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      tmo_d     = '0;
      idx_d     = '0;
      asm_d     = '0;
      timeout_d = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      asm_q     <= '0;
      idx_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      idx_q     <= idx_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

`ifdef HOST_RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule

// File: rtl/uart_host_endpoint.sv
// -----------------------------------------------------------------------------
// uart_host_endpoint: host-side end of the processor UART link.
//   TX: INP_WIDTH packets from s_axis are sent LSB byte first (top byte
//       zero-padded) as 8N1 characters on txd.
//   RX: bytes on rxd are reassembled into OUT_WIDTH words on m_axis.
// Optional macro HOST_RX_TIMEOUT_EN enables the rx partial-word timeout.
// Ports:
//   clk, arstn                 clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready packet to send
//   m_axis_tdata/tvalid/tready word received
//   rxd / txd                  serial in / out (idle high)
//   rx_busy / tx_busy          uart receiver / transmitter mid-frame
//   rx_error                   sticky frame or overrun error
//   rx_timeout                 sticky partial-word timeout
// -----------------------------------------------------------------------------
module uart_host_endpoint
  import uart_config::*;
  import processor_config::*;
#(
  parameter real CLK_FREQ      = 100.0e6,
  parameter int  BAUD_RATE     = 115_200,
  parameter int  TIMEOUT_CHARS = 16
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic [INP_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic                 rxd,
  output logic                 txd,
  output logic                 rx_busy,
  output logic                 tx_busy,
  output logic                 rx_error,
  output logic                 rx_timeout
);

  localparam int          INP_BYTES      = (INP_WIDTH + 7) / 8;
  localparam int          BCNT_W         = (INP_BYTES > 1) ? $clog2(INP_BYTES) : 1;
  localparam int          PRESCALE       = calc_prescale(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] PRESCALE_16    = 16'(PRESCALE);
  localparam int          TIMEOUT_CYCLES = TIMEOUT_CHARS * calc_char_clocks(CLK_FREQ, BAUD_RATE);

  logic [UART_WIDTH-1:0] tx_tdata;
  logic                  tx_tvalid;
  logic                  tx_tready;
  logic [UART_WIDTH-1:0] rx_tdata;
  logic                  rx_tvalid;
  logic                  rx_tready;
  logic                  frame_err;
  logic                  overrun_err;

  uart_core u_uart (
    .clk         (clk),
    .arstn       (arstn),
    .prescale    (PRESCALE_16),
    .tx_tdata    (tx_tdata),
    .tx_tvalid   (tx_tvalid),
    .tx_tready   (tx_tready),
    .rx_tdata    (rx_tdata),
    .rx_tvalid   (rx_tvalid),
    .rx_tready   (rx_tready),
    .rxd         (rxd),
    .txd         (txd),
    .tx_busy     (tx_busy),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  uart_word_unpacker #(
    .OUT_WIDTH      (OUT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_unpacker (
    .clk           (clk),
    .arstn         (arstn),
    .rx_tdata      (rx_tdata),
    .rx_tvalid     (rx_tvalid),
    .rx_tready     (rx_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .rx_timeout    (rx_timeout)
  );

  // ---------------------------------------------------------------- TX FSM
  tx_state_e              state_q,    state_d;
  logic [8*INP_BYTES-1:0] shreg_q,    shreg_d;
  logic [BCNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic                   s_ready_q;
  logic                   rx_error_q;

  assign s_axis_tready = s_ready_q;
  assign rx_error      = rx_error_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    tx_tvalid  = 1'b0;
    tx_tdata   = shreg_q[7:0];
    case (state_q)
      TX_IDLE: begin
        if (s_axis_tvalid && s_ready_q) begin
          shreg_d                  = '0;
          shreg_d[INP_WIDTH-1:0]   = s_axis_tdata;
          byte_cnt_d               = '0;
          state_d                  = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_tvalid = 1'b1;
        if (tx_tready) begin
          shreg_d    = shreg_q >> 8;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == BCNT_W'(INP_BYTES - 1)) state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Ready is registered so it stays low through reset and rises on the
  // first edge after release.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= TX_IDLE;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      s_ready_q  <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      s_ready_q  <= (state_d == TX_IDLE);
      rx_error_q <= rx_error_q | frame_err | overrun_err;
    end
  end

endmodule

// File: tb/tb_uart_host_endpoint.sv
`timescale 1ns/1ps
module tb_uart_host_endpoint;
  import processor_config::*;

  localparam real CLK_FREQ = 100.0e6;
  localparam int  BAUD     = 1_250_000;  // CLK_FREQ/80
  localparam int  BIT      = 80;         // clocks per bit

  logic                 clk;
  logic                 arstn;
  logic [INP_WIDTH-1:0] s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [OUT_WIDTH-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 rxd;
  logic                 txd;
  logic                 rx_busy;
  logic                 tx_busy;
  logic                 rx_error;
  logic                 rx_timeout;

  uart_host_endpoint #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUD_RATE     (BAUD),
    .TIMEOUT_CHARS (16)
  ) dut (
    .clk           (clk),
    .arstn         (arstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .rxd           (rxd),
    .txd           (txd),
    .rx_busy       (rx_busy),
    .tx_busy       (tx_busy),
    .rx_error      (rx_error),
    .rx_timeout    (rx_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Bench UART transmitter into rxd; stop_bit=0 forces a framing error.
  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT / 4) @(negedge clk);
    $display("rx byte 0x%02h stop=%0d sent", b, stop_bit);
  endtask

  // Bench UART receiver on txd; returns mid stop bit.
  task automatic tx_capture(output logic [7:0] b, output logic ok);
    int waited;
    waited = 0;
    ok = 1'b0;
    b  = 8'h00;
    while (txd !== 1'b0 && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    if (txd === 1'b0) begin
      repeat (BIT / 2) @(negedge clk);
      ok = (txd === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = txd;
      end
      repeat (BIT) @(negedge clk);
      ok = ok && (txd === 1'b1);
    end
    $display("tx byte 0x%02h framed=%0d captured", b, ok);
  endtask

  task automatic pulse_reset();
    arstn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish in cycle budget");
    $fatal(1, "watchdog");
  end

  logic [7:0] b;
  logic       ok;
  int         cnt;

  initial begin
    n_pass = 0;
    n_total = 0;
    arstn = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    rxd = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_s_ready", s_axis_tready, 0);
    check("rst_m_valid", m_axis_tvalid, 0);
    check("rst_m_data", m_axis_tdata, 0);
    check("rst_rx_error", rx_error, 0);
    check("rst_rx_timeout", rx_timeout, 0);
    check("rst_txd", txd, 1);
    check("rst_tx_busy", tx_busy, 0);
    arstn = 1'b1;
    @(negedge clk);
    check("s_ready_after_release", s_axis_tready, 1);

    // TX 0xABC -> 0xBC, 0x0A
    s_axis_tdata = 12'hABC;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    check("s_ready_after_accept", s_axis_tready, 0);
    tx_capture(b, ok);
    check("tx0_framing", ok, 1);
    check("tx0_byte0", b, 8'hBC);
    check("s_ready_between_bytes", s_axis_tready, 0);
    tx_capture(b, ok);
    check("tx0_framing1", ok, 1);
    check("tx0_byte1", b, 8'h0A);
    check("s_ready_after_word", s_axis_tready, 1);
    cnt = 0;
    while (tx_busy !== 1'b0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("tx_idle", tx_busy, 0);
    check("txd_idle", txd, 1);

    // RX 0x45,0x23,0xF1 -> 0x12345
    rx_send(8'h45, 1'b1);
    rx_send(8'h23, 1'b1);
    check("rx_not_yet_valid", m_axis_tvalid, 0);
    rx_send(8'hF1, 1'b1);
    check("rx0_valid", m_axis_tvalid, 1);
    check("rx0_data", m_axis_tdata, 20'h12345);
    check("rx0_no_error", rx_error, 0);
    repeat (10) @(negedge clk);
    check("rx0_held_valid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    check("rx0_cleared", m_axis_tvalid, 0);

    // Overrun: two words with m_axis_tready low
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    rx_send(8'h33, 1'b1);
    check("rx1_data", m_axis_tdata, 20'h32211);
    rx_send(8'h44, 1'b1);
    rx_send(8'h55, 1'b1);
    rx_send(8'h66, 1'b1);
    check("ovr_valid", m_axis_tvalid, 1);
    check("ovr_data_intact", m_axis_tdata, 20'h32211);
    check("ovr_rx_error", rx_error, 1);
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    repeat (5) @(negedge clk);
    check("ovr_error_sticky", rx_error, 1);
    pulse_reset();
    check("rst2_rx_error", rx_error, 0);
    check("rst2_m_valid", m_axis_tvalid, 0);
    arstn = 1'b1;
    @(negedge clk);

    // Framing error, sticky across a good word
    rx_send(8'h5A, 1'b0);
    check("frame_rx_error", rx_error, 1);
    check("frame_no_word", m_axis_tvalid, 0);
    rx_send(8'hA1, 1'b1);
    rx_send(8'hB2, 1'b1);
    rx_send(8'hC3, 1'b1);
    check("post_frame_data", m_axis_tdata, 20'h3B2A1);
    check("post_frame_error", rx_error, 1);
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    pulse_reset();
    check("rst3_rx_error", rx_error, 0);
    arstn = 1'b1;
    @(negedge clk);

    // Partial word then long silence
    rx_send(8'h11, 1'b1);
    repeat (12400) @(negedge clk);
    check("tmo_not_early", rx_timeout, 0);
    repeat (600) @(negedge clk);
`ifdef HOST_RX_TIMEOUT_EN
    check("tmo_set", rx_timeout, 1);
    rx_send(8'h01, 1'b1);
    rx_send(8'h02, 1'b1);
    rx_send(8'h03, 1'b1);
    check("tmo_word_valid", m_axis_tvalid, 1);
    check("tmo_word_data", m_axis_tdata, 20'h30201);
    check("tmo_sticky", rx_timeout, 1);
`else
    check("tmo_disabled", rx_timeout, 0);
    rx_send(8'h02, 1'b1);
    rx_send(8'h03, 1'b1);
    check("notmo_word_valid", m_axis_tvalid, 1);
    check("notmo_word_data", m_axis_tdata, 20'h30211);
`endif
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    check("tmo_word_cleared", m_axis_tvalid, 0);

    // Reset in the middle of a tx word
    s_axis_tdata = 12'hABC;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    tx_capture(b, ok);
    check("abort_byte0", b, 8'hBC);
    arstn = 1'b0;
    @(negedge clk);
    check("abort_txd_high", txd, 1);
    check("abort_s_ready_low", s_axis_tready, 0);
    check("abort_tx_busy", tx_busy, 0);
    repeat (5) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    check("abort_s_ready_back", s_axis_tready, 1);
    cnt = 0;
    repeat (1800) begin
      @(negedge clk);
      if (txd !== 1'b1) cnt++;
    end
    check("abort_no_second_byte", cnt, 0);
    s_axis_tdata = 12'h5A7;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    tx_capture(b, ok);
    check("tx1_byte0", b, 8'hA7);
    tx_capture(b, ok);
    check("tx1_byte1", b, 8'h05);
    check("tx1_framing", ok, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
